// File: rtl/search_scheduler.sv
// search_scheduler: round-robin front end for a shared bisection engine.
// Captures one request at a time, runs WIDTH bisection iterations on the
// captured target, and returns the converged value tagged with the index
// of the requester that owns it over a valid/ready response port.
module search_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data
);

   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
   localparam logic [ID_W:0]     N_WRAP   = (ID_W + 1)'(N_REQ);
   localparam logic [WIDTH-1:0]  ALL_ONES = '1;
   localparam logic [N_REQ-1:0]  GNT_ONE  = N_REQ'(1);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      RESP
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  v;
   logic [WIDTH-1:0]  b;
   logic [WIDTH-1:0]  e;
   logic [CNT_W-1:0]  cnt;
   logic [ID_W-1:0]   id;
   logic [ID_W-1:0]   rr_ptr;

   logic [WIDTH-1:0]  req_slice [N_REQ];
   logic              sel_found;
   logic [ID_W-1:0]   sel_idx;
   logic [ID_W:0]     scan_sum;

   logic [WIDTH:0]    sum_w;
   logic [WIDTH-1:0]  mid;
   logic [WIDTH-1:0]  mid_inc;
   logic              go_up;

   // Split the flat target bus into one slice per requester.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_slice[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin pick: first active request at or above rr_ptr, wrapping to 0.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_sum  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (scan_sum >= N_WRAP) begin
            scan_sum = scan_sum - N_WRAP;
         end
         if (!sel_found && req[scan_sum[ID_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_sum[ID_W-1:0];
         end
      end
   end

   // Midpoint uses a WIDTH+1 bit sum so b+e cannot wrap when e is all ones.
   assign sum_w   = {1'b0, b} + {1'b0, e};
   assign mid     = WIDTH'(sum_w >> 1);
   assign mid_inc = mid + WIDTH'(1);
   assign go_up   = (v > mid);

   // Scheduler FSM: capture, iterate the bisection, hold the response until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         v         <= '0;
         b         <= '0;
         e         <= ALL_ONES;
         cnt       <= '0;
         id        <= '0;
         rr_ptr    <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  v     <= req_slice[sel_idx];
                  id    <= sel_idx;
                  b     <= '0;
                  e     <= ALL_ONES;
                  cnt   <= '0;
                  gnt   <= GNT_ONE << sel_idx;
                  busy  <= 1'b1;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (go_up) begin
                  b <= mid_inc;
               end else begin
                  e <= mid;
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  rsp_data  <= go_up ? mid_inc : mid;
                  rsp_id    <= id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  rr_ptr    <= (id == ID_LAST) ? '0 : id + ID_W'(1);
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_search_scheduler.sv
// tb_search_scheduler: scoreboard bench for search_scheduler.
// A cycle-level reference tracks grant, busy and valid timing; expected
// (id, target) pairs are queued at each capture and compared while the
// response is presented.
module tb_search_scheduler;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int ID_W  = 2;

   logic                   clk;
   logic                   rst;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       gnt;
   logic                   busy;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_data;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb [$];

   int tests_run;
   int tests_failed;

   // reference model state
   int               m_state;
   int               m_cnt;
   int               m_ptr;
   int               m_id;
   logic [N_REQ-1:0] m_gnt;
   logic             m_busy;
   logic             m_valid;

   logic [N_REQ-1:0]       req_s;
   logic [N_REQ*WIDTH-1:0] data_s;
   logic                   ready_s;
   logic                   rst_s;
   int                     pick;
   exp_t                   entry;

   search_scheduler #(
      .N_REQ (N_REQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pickReq(input logic [N_REQ-1:0] r, input int ptr);
      for (int k = 0; k < N_REQ; k++) begin
         if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
      end
      return -1;
   endfunction

   // Reference model advances on each edge from the sampled inputs, then outputs are compared 1 time unit later.
   always @(posedge clk) begin
      req_s   = req;
      data_s  = req_data;
      ready_s = rsp_ready;
      rst_s   = rst;
      if (rst_s) begin
         m_state = 0;
         m_cnt   = 0;
         m_ptr   = 0;
         m_id    = 0;
         m_gnt   = '0;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         sb.delete();
      end else begin
         case (m_state)
            0: begin
               m_gnt = '0;
               pick  = pickReq(req_s, m_ptr);
               if (pick >= 0) begin
                  m_gnt      = N_REQ'(1) << pick;
                  m_busy     = 1'b1;
                  m_id       = pick;
                  m_cnt      = 0;
                  m_state    = 1;
                  entry.id   = pick;
                  entry.data = data_s[pick*WIDTH +: WIDTH];
                  sb.push_back(entry);
               end
            end
            1: begin
               m_gnt = '0;
               m_cnt++;
               if (m_cnt == WIDTH) begin
                  m_valid = 1'b1;
                  m_state = 2;
               end
            end
            default: begin
               m_gnt = '0;
               if (ready_s) begin
                  m_valid = 1'b0;
                  m_busy  = 1'b0;
                  m_ptr   = (m_id + 1) % N_REQ;
                  m_state = 0;
                  if (sb.size() > 0) void'(sb.pop_front());
               end
            end
         endcase
      end
      #1;
      checkOutput("gnt", 32'(gnt), 32'(m_gnt));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid && sb.size() > 0) begin
         checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
         checkOutput("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      end
   end

   task automatic waitGnt(input int idx);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (gnt[idx]) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput($sformatf("gnt_wait_%0d", idx), 32'(seen), 32'd1);
      req[idx] = 1'b0;
      req_data[idx*WIDTH +: WIDTH] = WIDTH'($urandom);
   endtask

   task automatic waitIdle(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (m_state == 0 && sb.size() == 0 && rsp_valid == 1'b0) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput("idle_wait", 32'(done), 32'd1);
   endtask

   task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] value);
      @(negedge clk);
      req_data[idx*WIDTH +: WIDTH] = value;
      req[idx] = 1'b1;
      waitGnt(idx);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_id"}, 32'(rsp_id), 32'd0);
      checkOutput({tag, "_data"}, 32'(rsp_data), 32'd0);
   endtask

   // Main stimulus sequence.
   initial begin
      logic [WIDTH-1:0] bounds [4];
      bit               seen;
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      req          = '0;
      req_data     = '0;
      rsp_ready    = 1'b1;
      bounds[0]    = 8'h00;
      bounds[1]    = 8'hFF;
      bounds[2]    = 8'h7F;
      bounds[3]    = 8'h80;

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      // single request from requester 2
      applyStimulus(2, 8'hA7);
      waitIdle(50);

      // boundary targets on rotating requesters
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i, bounds[i]);
         waitIdle(50);
      end

      // exhaustive sweep of all target values
      for (int t = 0; t < 256; t++) begin
         applyStimulus(t % N_REQ, WIDTH'(t));
         waitIdle(50);
      end

      // round-robin with all requests held high
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
         req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h11 * (i + 3));
      end
      req = '1;
      repeat (85) @(negedge clk);
      req = '0;
      waitIdle(50);

      // backpressure with a competing request arriving during the response
      @(negedge clk);
      rsp_ready = 1'b0;
      applyStimulus(1, 8'h3C);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("bp_valid_wait", 32'(seen), 32'd1);
      req_data[3*WIDTH +: WIDTH] = 8'hC3;
      req[3] = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_data_hold", 32'(rsp_data), 32'h3C);
      rsp_ready = 1'b1;
      waitGnt(3);
      waitIdle(50);

      // reset in the middle of a search
      applyStimulus(0, 8'h55);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetOutputs("midrst");
      req_data[1*WIDTH +: WIDTH] = 8'h9D;
      req_data[3*WIDTH +: WIDTH] = 8'h26;
      req = 4'b1010;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      waitGnt(1);
      checkOutput("midrst_first_gnt", 32'(gnt), 32'b0010);
      waitGnt(3);
      waitIdle(50);

      // late request raised while another requester is searching
      applyStimulus(1, 8'h12);
      repeat (3) @(negedge clk);
      req_data[3*WIDTH +: WIDTH] = 8'hE9;
      req[3] = 1'b1;
      waitGnt(3);
      waitIdle(50);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/search_scheduler.md
# search_scheduler

Shared-engine scheduler for the 8-cycle binary-search datapath. Accepts search requests from `N_REQ` requesters and arbitrates round-robin. It sequences one embedded bisection engine through exactly `WIDTH` iterations per request and returns the converged value tagged with the requester index over a valid/ready response port. It sits between the requester blocks and the search datapath, and owns its start, iteration count and reset-to-bounds.

## Interface
- `N_REQ`, 4, number of requesters (2..16).
- `WIDTH`, 8, search value width; the engine runs `WIDTH` iterations per request.
- `ID_W`, derived: clog2(`N_REQ`), minimum 1; width of `rsp_id`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `N_REQ`  per-requester request level.
- `req_data`  in  `N_REQ*WIDTH`  target values; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  `N_REQ`  registered one-hot, one-cycle pulse: the request of that index was captured.
- `busy`  out  1  high in SEARCH and RESP.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  `ID_W`  index of the requester owning `rsp_data`.
- `rsp_data`  out  `WIDTH`  search result.

## Operation
- States: IDLE, SEARCH, RESP. Reset state is IDLE.
- Registers: `v` (captured target), `b`, `e`, `cnt`, `id`, `rr_ptr`.
- Reset values: `gnt`=0, `busy`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rr_ptr`=0, `cnt`=0, `b`=0, `e`=all-ones.
- IDLE with `req`≠0:
  - Select the first set bit scanning from `rr_ptr` upward, wrapping at `N_REQ`-1 to 0.
  - Capture `v` from that requester's slice and set `id` to the selected index.
  - Load `b`=0, `e`=2^`WIDTH`-1 and `cnt`=0.
  - Set `gnt` to the one-hot of `id` for exactly one cycle, and go to SEARCH.
- IDLE with `req`=0: all registers hold and `gnt`=0.
- SEARCH, each edge:
  - `m` = (`b`+`e`)>>1, with the sum computed in `WIDTH`+1 bits. No overflow is permitted, including at `e`=all-ones.
  - If `v`>`m`, `b`←`m`+1; else `e`←`m`. `m`+1 cannot overflow because `v`>`m` implies `m`<max.
  - `cnt`←`cnt`+1.
  - On the edge where `cnt`=`WIDTH`-1: load `rsp_data` with the post-update `b` value, i.e. (`v`>`m`) ? `m`+1 : `m`. Load `rsp_id`←`id`, set `rsp_valid`←1, and go to RESP.
  - The result equals `v` for every input.
- RESP:
  - `rsp_valid`, `rsp_id` and `rsp_data` hold stable until `rsp_valid`&`rsp_ready` is sampled at an edge.
  - On that edge: `rsp_valid`←0, `rr_ptr`←(`id`+1) mod `N_REQ`, and go to IDLE.
  - `rsp_id` and `rsp_data` keep their last values after the handshake.
- `req` is sampled only in IDLE. Requests raised or changed during SEARCH/RESP wait and are never lost while held.
- `req_data` of the granted requester need not be stable after the capture edge.
- `rsp_ready` high outside RESP has no effect.

## Timing
- Capture edge E0 puts `gnt` and `busy` high in the following cycle.
- Edges E1..E`WIDTH` perform the iterations. `rsp_valid` rises after E`WIDTH`, i.e. `WIDTH` cycles after the `gnt` pulse.
- With `rsp_ready` tied high, the handshake occurs at E`WIDTH`+1 and the next capture at E`WIDTH`+2. Steady-state throughput is one request per `WIDTH`+2 cycles (10 for `WIDTH`=8).
- `busy` falls on the handshake edge and `gnt` never overlaps `rsp_valid`.
- No back-to-back grant without passing through IDLE for one edge.
- Asserting `rst` at any time returns to IDLE immediately, asynchronously, with all outputs at their reset values. An in-flight search is discarded and no response is issued. After release, the first grant goes to the lowest-indexed active requester.

## Test plan
- Single request, `N_REQ`=4, `WIDTH`=8, requester 2 with `req_data`=0xA7 and `rsp_ready`=1 → `gnt`=4'b0100 for one cycle. 8 cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_data`=0xA7 for exactly one cycle.
- Boundary values: targets 0x00, 0xFF, 0x7F and 0x80 each → `rsp_data` equals the target, which checks the (`WIDTH`+1)-bit midpoint with no wrap at `e`=0xFF. Then an exhaustive sweep of 0..255 with every result equal to its input.
- Round-robin: all four `req` held high continuously → grant order 0,1,2,3,0,… with `gnt` pulses exactly 10 cycles apart and each `rsp_id` matching the preceding grant.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises → `rsp_valid`/`rsp_id`/`rsp_data` stable, `busy`=1, no new `gnt`. The handshake completes on the first cycle `rsp_ready`=1.
- Reset mid-search: assert `rst` 3 cycles after a `gnt` → all outputs zero at once and no `rsp_valid`. After release with `req`=4'b1010, `gnt`=4'b0010 first.
- Late request: requester 3 raises `req` while requester 1 is in SEARCH → served immediately after requester 1's handshake with the correct `rsp_data`.
